// File: rtl/vga_anim_pkg.sv
// Shared constants for the VGA block animator: colours, per-block start table
// and the per-axis wrap/bounce step functions.
package vga_anim_pkg;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_RED    = 12'h00F;
    localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE   = 12'hF00;
    localparam logic [11:0] COLOR_YELLOW = 12'h0FF;
    localparam logic [11:0] COLOR_WHITE  = 12'hFFF;

    localparam logic [11:0] BG_COLOR = COLOR_BLACK;

    localparam logic [9:0] INIT_X [0:7] = '{10'd50, 10'd80, 10'd630, 10'd5,
                                            10'd585, 10'd300, 10'd400, 10'd500};
    localparam logic [9:0] INIT_Y [0:7] = '{10'd50, 10'd80, 10'd200, 10'd300,
                                            10'd400, 10'd100, 10'd150, 10'd250};
    localparam logic INIT_DXN [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic INIT_DYN [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [11:0] BLOCK_COLOR [0:7] = '{COLOR_RED, COLOR_GREEN, COLOR_BLUE,
                                                  COLOR_YELLOW, COLOR_WHITE, COLOR_RED,
                                                  COLOR_GREEN, COLOR_BLUE};

    typedef struct packed {
        logic       neg;
        logic [9:0] pos;
    } axis_t;

    function automatic axis_t wrap_step(input logic [9:0] pos, input logic neg,
                                        input logic [10:0] limit, input logic [10:0] step);
        logic [10:0] p;
        axis_t       r;
        p     = {1'b0, pos};
        r.neg = neg;
        if (!neg)
            r.pos = (p + step >= limit) ? 10'(p + step - limit) : 10'(p + step);
        else
            r.pos = (p < step) ? 10'(p + limit - step) : 10'(p - step);
        return r;
    endfunction

    // Clamps to the edge and reverses, so an out-of-range start is pulled in on the first move.
    function automatic axis_t bounce_step(input logic [9:0] pos, input logic neg,
                                          input logic [10:0] limit, input logic [10:0] size,
                                          input logic [10:0] step);
        logic [10:0] p;
        axis_t       r;
        p     = {1'b0, pos};
        r.neg = neg;
        r.pos = pos;
        if (!neg) begin
            if (p + size + step > limit) begin
                r.pos = 10'(limit - size);
                r.neg = ~neg;
            end else begin
                r.pos = 10'(p + step);
            end
        end else begin
            if (p < step) begin
                r.pos = 10'd0;
                r.neg = ~neg;
            end else begin
                r.pos = 10'(p - step);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_block_mover.sv
// One animated block: position/direction registers, per-move update and hit test.
// Bounce vs wrap edge behaviour is selected by VGA_ANIM_BOUNCE_EN.
module vga_block_mover
    import vga_anim_pkg::*;
#(
    parameter int IDX      = 0,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BLOCK_W  = 50,
    parameter int BLOCK_H  = 50,
    parameter int STEP     = 10
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       move,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       hit
);

    logic [9:0] x, y;
    logic       dx_neg, dy_neg;
    axis_t      nx, ny;

    always_comb begin
`ifdef VGA_ANIM_BOUNCE_EN
        nx = bounce_step(x, dx_neg, 11'(H_ACTIVE), 11'(BLOCK_W), 11'(STEP));
        ny = bounce_step(y, dy_neg, 11'(V_ACTIVE), 11'(BLOCK_H), 11'(STEP));
`else
        nx = wrap_step(x, dx_neg, 11'(H_ACTIVE), 11'(STEP));
        ny = wrap_step(y, dy_neg, 11'(V_ACTIVE), 11'(STEP));
`endif
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            x      <= INIT_X[IDX];
            y      <= INIT_Y[IDX];
            dx_neg <= INIT_DXN[IDX];
            dy_neg <= INIT_DYN[IDX];
        end else if (move) begin
            x      <= nx.pos;
            y      <= ny.pos;
            dx_neg <= nx.neg;
            dy_neg <= ny.neg;
        end
    end

    // 11-bit compare so a block straddling the right/bottom edge never aliases.
    assign hit = ({1'b0, pixel_x} >= {1'b0, x}) &&
                 ({1'b0, pixel_x} <  {1'b0, x} + 11'(BLOCK_W)) &&
                 ({1'b0, pixel_y} >= {1'b0, y}) &&
                 ({1'b0, pixel_y} <  {1'b0, y} + 11'(BLOCK_H));

endmodule

// File: rtl/vga_block_animator.sv
// Multi-block renderer/animator between VGA_controller and the 12-bit vga pins.
// Define VGA_ANIM_BOUNCE_EN for bounce-off-edge motion; default is wrap-around.
module vga_block_animator
    import vga_anim_pkg::*;
#(
    parameter int N_BLOCKS  = 4,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BLOCK_W   = 50,
    parameter int BLOCK_H   = 50,
    parameter int STEP      = 10,
    parameter int FRAME_DIV = 2
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        pixel_clk,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        run,
    output logic [11:0] vga
);

    logic                frame_tick;
    logic                move;
    logic [7:0]          div_cnt;
    logic [N_BLOCKS-1:0] hit;
    logic [11:0]         vga_next;

    // First blanking line start: moves land here so no visible frame tears.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            frame_tick <= 1'b0;
        else
            frame_tick <= pixel_clk && (pixel_y == 10'(V_ACTIVE)) && (pixel_x == 10'd0);
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            div_cnt <= 8'd0;
            move    <= 1'b0;
        end else begin
            move <= 1'b0;
            if (frame_tick && run) begin
                if (div_cnt == 8'(FRAME_DIV - 1)) begin
                    div_cnt <= 8'd0;
                    move    <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < N_BLOCKS; i++) begin : g_blk
        vga_block_mover #(
            .IDX      (i),
            .H_ACTIVE (H_ACTIVE),
            .V_ACTIVE (V_ACTIVE),
            .BLOCK_W  (BLOCK_W),
            .BLOCK_H  (BLOCK_H),
            .STEP     (STEP)
        ) u_mover (
            .CLK100MHZ (CLK100MHZ),
            .reset     (reset),
            .move      (move),
            .pixel_x   (pixel_x),
            .pixel_y   (pixel_y),
            .hit       (hit[i])
        );
    end

    // Scan high to low so the lowest-index hit wins.
    always_comb begin
        vga_next = BG_COLOR;
        for (int i = N_BLOCKS - 1; i >= 0; i--) begin
            if (hit[i])
                vga_next = BLOCK_COLOR[i];
        end
        if (!video_on)
            vga_next = COLOR_BLACK;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            vga <= 12'h000;
        else if (pixel_clk)
            vga <= vga_next;
    end

endmodule

// File: tb/tb_vga_block_animator.sv
// Scoreboard bench for vga_block_animator: stimulus queues expectations, a monitor checks them.
module tb_vga_block_animator;

    localparam int K_VGA = 0, K_DIV = 1, K_X = 2, K_Y = 3, K_DXN = 4;

`ifdef VGA_ANIM_BOUNCE_EN
    localparam int B2X1 = 590, B2D1 = 1, B3X1 = 0,   B3D1 = 0, B4X1 = 590, B4D1 = 1;
    localparam int B2X2 = 580, B3X2 = 10, B4X2 = 580;
`else
    localparam int B2X1 = 0,   B2D1 = 0, B3X1 = 635, B3D1 = 1, B4X1 = 595, B4D1 = 0;
    localparam int B2X2 = 10,  B3X2 = 625, B4X2 = 605;
`endif

    logic        CLK100MHZ = 1'b0;
    logic        reset;
    logic        pixel_clk;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        run;
    logic [11:0] vga;

    logic chk = 1'b0, probe = 1'b0;
    logic chk_seen = 1'b0, probe_seen = 1'b0;

    typedef struct {
        int    kind;
        int    idx;
        int    exp;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    vga_block_animator #(
        .N_BLOCKS  (5),
        .FRAME_DIV (2)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .pixel_clk (pixel_clk),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .run       (run),
        .vga       (vga)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) begin
        chk_seen   <= chk & pixel_clk;
        probe_seen <= probe;
    end

    function automatic int get_val(input int kind, input int idx);
        int v;
        v = -1;
        case (kind)
            K_VGA: v = int'(vga);
            K_DIV: v = int'(dut.div_cnt);
            K_X: case (idx)
                0: v = int'(dut.g_blk[0].u_mover.x);
                1: v = int'(dut.g_blk[1].u_mover.x);
                2: v = int'(dut.g_blk[2].u_mover.x);
                3: v = int'(dut.g_blk[3].u_mover.x);
                4: v = int'(dut.g_blk[4].u_mover.x);
                default: v = -1;
            endcase
            K_Y: case (idx)
                0: v = int'(dut.g_blk[0].u_mover.y);
                default: v = -1;
            endcase
            K_DXN: case (idx)
                2: v = int'(dut.g_blk[2].u_mover.dx_neg);
                3: v = int'(dut.g_blk[3].u_mover.dx_neg);
                4: v = int'(dut.g_blk[4].u_mover.dx_neg);
                default: v = -1;
            endcase
            default: v = -1;
        endcase
        return v;
    endfunction

    always @(negedge CLK100MHZ) begin
        if (chk_seen || probe_seen) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty got output with no expectation queued");
            end else begin
                exp_t e;
                int   act;
                e   = q.pop_front();
                act = get_val(e.kind, e.idx);
                checks++;
                if (act != e.exp) begin
                    errors++;
                    $display("FAIL %s actual %0d (0x%0h) required %0d (0x%0h)",
                             e.name, act, act, e.exp, e.exp);
                end
            end
        end
    end

    task automatic pix(input int px, input int py, input bit von, input int exp, input string nm);
        @(posedge CLK100MHZ); #1;
        pixel_x   = 10'(px);
        pixel_y   = 10'(py);
        video_on  = von;
        pixel_clk = 1'b1;
        chk       = 1'b1;
        q.push_back('{K_VGA, 0, exp, nm});
        @(posedge CLK100MHZ); #1;
        pixel_clk = 1'b0;
        chk       = 1'b0;
    endtask

    task automatic chk_state(input int kind, input int idx, input int exp, input string nm);
        @(posedge CLK100MHZ); #1;
        probe = 1'b1;
        q.push_back('{kind, idx, exp, nm});
        @(posedge CLK100MHZ); #1;
        probe = 1'b0;
    endtask

    // run_after is applied the cycle frame_tick is high, to exercise run falling with it.
    task automatic tick(input bit run_after);
        @(posedge CLK100MHZ); #1;
        pixel_x   = 10'd0;
        pixel_y   = 10'd480;
        video_on  = 1'b0;
        pixel_clk = 1'b1;
        @(posedge CLK100MHZ); #1;
        pixel_clk = 1'b0;
        pixel_y   = 10'd481;
        run       = run_after;
        repeat (3) @(posedge CLK100MHZ);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual still running required finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1; pixel_clk = 1'b0; video_on = 1'b0;
        pixel_x = 10'd0; pixel_y = 10'd0; run = 1'b1;
        repeat (3) @(posedge CLK100MHZ);
        #1 reset = 1'b0;

        chk_state(K_VGA, 0, 0,  "reset_vga");
        chk_state(K_DIV, 0, 0,  "reset_div");
        chk_state(K_X,   0, 50, "reset_b0_x");
        chk_state(K_Y,   0, 50, "reset_b0_y");

        pix(60,  60,  1, 'h00F, "b0_inside");
        pix(90,  90,  1, 'h00F, "overlap_prio");
        pix(90,  90,  0, 'h000, "overlap_blank");
        pix(120, 120, 1, 'h0F0, "b1_only");
        pix(49,  60,  1, 'h000, "b0_left_edge");
        pix(99,  60,  1, 'h00F, "b0_right_edge");
        pix(100, 60,  1, 'h000, "b0_past_right");
        pix(635, 210, 1, 'hF00, "b2_straddle");
        pix(4,   300, 1, 'h000, "b3_left_out");
        pix(5,   300, 1, 'h0FF, "b3_left_in");
        pix(400, 30,  1, 'h000, "background");

        pix(0, 100, 1, 'h000, "active_line");
        pix(1, 480, 0, 'h000, "blank_not_x0");
        chk_state(K_X,   0, 50, "no_tick_b0_x");
        chk_state(K_DIV, 0, 0,  "no_tick_div");

        tick(1'b1);
        chk_state(K_DIV, 0, 1,  "tick1_div");
        chk_state(K_X,   0, 50, "tick1_b0_x");
        tick(1'b1);
        chk_state(K_DIV, 0, 0,    "tick2_div");
        chk_state(K_X,   0, 60,   "tick2_b0_x");
        chk_state(K_Y,   0, 60,   "tick2_b0_y");
        chk_state(K_X,   2, B2X1, "move1_b2_x");
        chk_state(K_DXN, 2, B2D1, "move1_b2_dxn");
        chk_state(K_X,   3, B3X1, "move1_b3_x");
        chk_state(K_DXN, 3, B3D1, "move1_b3_dxn");
        chk_state(K_X,   4, B4X1, "move1_b4_x");
        chk_state(K_DXN, 4, B4D1, "move1_b4_dxn");

        tick(1'b1);
        tick(1'b1);
        chk_state(K_X, 0, 70,   "tick4_b0_x");
        chk_state(K_X, 2, B2X2, "move2_b2_x");
        chk_state(K_X, 3, B3X2, "move2_b3_x");
        chk_state(K_X, 4, B4X2, "move2_b4_x");
        pix(100, 100, 1, 'h00F, "overlap_100");
        pix(100, 100, 0, 'h000, "overlap_100_blank");

        tick(1'b1);
        chk_state(K_DIV, 0, 1, "tick5_div");
        run = 1'b0;
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk_state(K_DIV, 0, 1,  "frozen_div");
        chk_state(K_X,   0, 70, "frozen_b0_x");

        run = 1'b1;
        tick(1'b0);
        chk_state(K_DIV, 0, 1,  "run_fall_div");
        chk_state(K_X,   0, 70, "run_fall_b0_x");
        run = 1'b1;
        tick(1'b1);
        chk_state(K_DIV, 0, 0,  "resume_div");
        chk_state(K_X,   0, 80, "resume_b0_x");

        pix(85, 85, 1, 'h00F, "pre_reset_red");
        @(posedge CLK100MHZ); #1;
        pixel_y = 10'd200;
        reset   = 1'b1;
        chk_state(K_VGA, 0, 0,  "midframe_reset_vga");
        chk_state(K_X,   0, 50, "midframe_reset_b0_x");
        chk_state(K_DIV, 0, 0,  "midframe_reset_div");
        @(posedge CLK100MHZ); #1 reset = 1'b0;

        tick(1'b1);
        chk_state(K_X,   0, 50, "post_reset_tick1_x");
        chk_state(K_DIV, 0, 1,  "post_reset_tick1_div");
        tick(1'b1);
        chk_state(K_X,   0, 60, "post_reset_tick2_x");

        repeat (4) @(posedge CLK100MHZ);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_block_animator.md
# vga_block_animator

Parametrised multi-block renderer and animator for the 640x480 VGA path. It sits between `VGA_controller` and the board's 12-bit `vga` pins and draws `N_BLOCKS` solid rectangles with fixed-priority overlap. It moves every block once per `FRAME_DIV` frames, and movement is synchronised to vertical blanking, so no block tears mid-frame. Each block's movement either wraps around the screen edge or bounces off it, selected at compile time.

## Interface
Parameters:
- `N_BLOCKS`, default 4: number of blocks, 1..8.
- `H_ACTIVE`, default 640: visible width in pixels.
- `V_ACTIVE`, default 480: visible height in lines.
- `BLOCK_W`, default 50: block width in pixels (all blocks).
- `BLOCK_H`, default 50: block height in lines (all blocks).
- `STEP`, default 10: pixels moved per axis per move event; must be less than `BLOCK_W` and less than `BLOCK_H`.
- `FRAME_DIV`, default 2: frames per move event, 1..255.

Ports (reset reset, asynchronous, active-high; clock CLK100MHZ):
- `CLK100MHZ`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pixel_clk`  in  1  one-cycle pixel enable strobe from `VGA_controller`.
- `video_on`  in  1  high while in the active area.
- `pixel_x`  in  10  current column.
- `pixel_y`  in  10  current line.
- `run`  in  1  motion enable; when low, positions freeze and drawing continues.
- `vga`  out  12  registered colour, {B[3:0], G[3:0], R[3:0]}.

## Operation
- Frame tick:
  - On a cycle where `pixel_clk` = 1, `pixel_y` = `V_ACTIVE` and `pixel_x` = 0, assert an internal `frame_tick` for exactly one `CLK100MHZ` cycle.
- Frame divider:
  - An 8-bit `div_cnt` increments on each `frame_tick` while `run` = 1.
  - When `div_cnt` reaches `FRAME_DIV`-1 together with a `frame_tick`, `div_cnt` returns to 0 and `move` pulses for one cycle.
  - While `run` = 0, `div_cnt` holds its value.
- Per-block state: `x[9:0]`, `y[9:0]`, `dx_neg`, `dy_neg`. Each block's initial values come from the package table.
- On `move`, each axis updates independently, computed in 11 bits:
  - Wrap mode, positive direction: if `x`+`STEP` >= `H_ACTIVE`, `x` becomes `x`+`STEP`-`H_ACTIVE`; otherwise `x` becomes `x`+`STEP`.
  - Wrap mode, negative direction: if `x` < `STEP`, `x` becomes `x`+`H_ACTIVE`-`STEP`; otherwise `x` becomes `x`-`STEP`.
  - The y axis follows the same rules with `V_ACTIVE`.
  - A block may straddle the right or bottom edge; its off-screen part is simply not drawn.
  - Bounce mode is described under Configuration.
- Hit test, per block i: `hit[i]` = (`x` <= `pixel_x` < `x`+`BLOCK_W`) AND (`y` <= `pixel_y` < `y`+`BLOCK_H`), compared in 11 bits.
- Colour selection:
  - If `video_on` = 0, `vga_next` is black.
  - Otherwise, the colour of the lowest-index block with `hit[i]` = 1.
  - If no block is hit, the package background colour, which is black.

## Timing
- `vga` loads `vga_next` only on `CLK100MHZ` edges where `pixel_clk` = 1. Latency is one pixel from `pixel_x`/`pixel_y` to `vga`.
- Positions change only in the cycle after `move`. `move` occurs during vertical blanking, so every active frame is drawn from a single position set.
- Reset values:
  - `vga` = 0.
  - `div_cnt` = 0.
  - Positions and direction bits take the package table values.
  - `frame_tick` = 0 and `move` = 0.
- Reset asserted mid-frame clears everything immediately. The first move after release happens on the `FRAME_DIV`-th `frame_tick`.
- If `run` falls in the same cycle as `frame_tick`, no `move` is generated and `div_cnt` holds.

## Configuration
- Macro: `VGA_ANIM_BOUNCE_EN`.
- Defined: bounce mode.
  - Positive direction: if `x`+`BLOCK_W`+`STEP` > `H_ACTIVE`, set `x` = `H_ACTIVE`-`BLOCK_W` and toggle `dx_neg`.
  - Negative direction: if `x` < `STEP`, set `x` = 0 and toggle `dx_neg`.
  - y axis: same rules with `V_ACTIVE` and `BLOCK_H`.
  - Blocks never leave the visible area.
  - If a package initial position is out of range, the first move clamps it.
- Undefined: wrap mode as described under Operation. The direction bits never change.

## Structure
- Package `vga_anim_pkg` holds:
  - Colour constants in BGR order: `COLOR_BLACK` 12'h000, `COLOR_RED` 12'h00F, `COLOR_GREEN` 12'h0F0, `COLOR_BLUE` 12'hF00, `COLOR_YELLOW` 12'h0FF, `COLOR_WHITE` 12'hFFF.
  - `BG_COLOR`.
  - Per-index tables for initial x, initial y, initial direction bits and colour, 8 entries each.
- Sub-module `vga_block_mover`:
  - One instance per block, via generate.
  - Owns the x/y/direction registers, the wrap/bounce update and `hit` generation.
  - Top level keeps the frame tick, divider, priority mux and output register.

## Test plan
- Reset, then sample `vga` and the positions: `vga` = 0 and block0 at (50,50) from the table. At (60,60) with `video_on` = 1, `vga` = 12'h00F one pixel later.
- `FRAME_DIV`=2, `run`=1: block0 x goes 50, then 60 after the 2nd `frame_tick`, then 70 after the 4th. No change occurs while `pixel_y` < 480.
- Wrap mode, block with x=630 moving positive, `STEP`=10: after one move x=0. From x=5 moving negative: after one move x=635.
- Bounce mode, x=585 moving positive, `BLOCK_W`=50: after one move x=590 and `dx_neg`=1. Next move gives x=580.
- Block0 and block1 overlapping at pixel (100,100): `vga` shows the block0 colour. With `video_on`=0 at the same pixel, `vga`=0.
- `run`=0 for 10 frames: positions and `div_cnt` are unchanged. Asserting reset mid-frame (y=200) gives `vga`=0 on the next edge.
